multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath (im/npc/pc/gpr/alu/dm/extend plus the RegDst, ALUSrc and DatatoReg muxes).

---
 rtl/mips_ctrl_pkg.sv | 70 +++++++
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/ctrl_decode.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller:
// FSM states, opcode/funct constants, instruction classes and mux-select codes.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_R    = 3'd1,
      CLS_IMM  = 3'd2,
      CLS_LW   = 3'd3,
      CLS_SW   = 3'd4,
      CLS_BEQ  = 3'd5,
      CLS_J    = 3'd6
   } instr_class_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_OR  = 5'd2;
   localparam logic [4:0] ALU_AND = 5'd3;
   localparam logic [4:0] ALU_SLT = 5'd4;
   localparam logic [4:0] ALU_LUI = 5'd5;

   localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
   localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;

   localparam logic [1:0] D2R_ALU = 2'd0;
   localparam logic [1:0] D2R_MEM = 2'd1;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic       alu_src;
      logic [4:0] alu_ctr;
      logic       ext_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] data_to_reg_sel;
      logic [1:0] pc_sel;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, mux selects and enables out.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             PCWrite;
   logic             IRWrite;
   logic [1:0]       RegDst;
   logic             ALUSrc;
   logic [4:0]       ALUCtr;
   logic             ExtOp;
   logic             MemRead;
   logic             MemWrite;
   logic             RegWrite;
   logic [1:0]       Data_to_Reg_sel;
   logic [1:0]       PC_sel;
   logic             instr_done;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output PCWrite, IRWrite, RegDst, ALUSrc, ALUCtr, ExtOp, MemRead, MemWrite,
             RegWrite, Data_to_Reg_sel, PC_sel, instr_done, illegal, retired
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  PCWrite, IRWrite, RegDst, ALUSrc, ALUCtr, ExtOp, MemRead, MemWrite,
             RegWrite, Data_to_Reg_sel, PC_sel, instr_done, illegal, retired
   );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to ALU controls, instruction class and legality.
module ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output logic [4:0]   alu_ctr,
   output logic         alu_src,
   output logic         ext_op,
   output instr_class_t instr_class,
   output logic         legal
);

   always_comb begin
      alu_ctr     = ALU_ADD;
      alu_src     = 1'b0;
      ext_op      = 1'b0;
      instr_class = CLS_NONE;
      legal       = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            instr_class = CLS_R;
            case (funct)
               FN_ADDU: alu_ctr = ALU_ADD;
               FN_SUBU: alu_ctr = ALU_SUB;
               FN_AND:  alu_ctr = ALU_AND;
               FN_OR:   alu_ctr = ALU_OR;
               FN_SLT:  alu_ctr = ALU_SLT;
               default: begin
                  instr_class = CLS_NONE;
                  legal       = 1'b0;
               end
            endcase
         end
         OP_ORI: begin
            instr_class = CLS_IMM;
            alu_src     = 1'b1;
            alu_ctr     = ALU_OR;
         end
         OP_LUI: begin
            instr_class = CLS_IMM;
            alu_src     = 1'b1;
            alu_ctr     = ALU_LUI;
         end
         OP_LW, OP_SW: begin
            instr_class = (opcode == OP_LW) ? CLS_LW : CLS_SW;
            alu_src     = 1'b1;
            ext_op      = 1'b1;
            alu_ctr     = ALU_ADD;
         end
         OP_BEQ: begin
            instr_class = CLS_BEQ;
            alu_ctr     = ALU_SUB;
         end
         OP_J:    instr_class = CLS_J;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with registered controls
// and a retired-instruction counter.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input logic              clk,
   input logic              reset,
   multicycle_ctrl_if.master bus
);

   state_t           state_q, state_d;
   logic             active_q, active_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [4:0]   dec_alu_ctr;
   logic         dec_alu_src;
   logic         dec_ext_op;
   instr_class_t dec_class;
   logic         dec_legal;
   logic         mem_done;
   logic         instr_done;

   ctrl_decode u_decode (
      .opcode      (bus.opcode),
      .funct       (bus.funct),
      .alu_ctr     (dec_alu_ctr),
      .alu_src     (dec_alu_src),
      .ext_op      (dec_ext_op),
      .instr_class (dec_class),
      .legal       (dec_legal)
   );

   // A store completes inside MEM, so its done pulse follows the ready handshake directly.
   assign mem_done   = !MEM_WAIT_EN || bus.mem_ready;
   assign instr_done = ctrl_q.instr_done | (ctrl_q.mem_write & mem_done);

   always_comb begin
      state_d  = state_q;
      active_d = 1'b1;
      if (!active_q) begin
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = dec_legal ? EXEC : FETCH;
            EXEC: begin
               case (dec_class)
                  CLS_R, CLS_IMM: state_d = WB;
                  CLS_LW, CLS_SW: state_d = MEM;
                  default:        state_d = FETCH;
               endcase
            end
            MEM:     if (mem_done) state_d = (dec_class == CLS_LW) ? WB : FETCH;
            WB:      state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end
   end

   // Controls are registered from the state being entered, so they line up with that state's cycle.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         FETCH: begin
            ctrl_d.ir_write = 1'b1;
            ctrl_d.pc_write = 1'b1;
            ctrl_d.pc_sel   = PC_SEL_SEQ;
         end
         DECODE: ctrl_d.illegal = !dec_legal;
         EXEC, MEM, WB: begin
            ctrl_d.alu_ctr = dec_alu_ctr;
            ctrl_d.alu_src = dec_alu_src;
            ctrl_d.ext_op  = dec_ext_op;
            if (state_d == EXEC && dec_class == CLS_BEQ) begin
               ctrl_d.pc_sel     = PC_SEL_BRANCH;
               ctrl_d.pc_write   = bus.zero;
               ctrl_d.instr_done = 1'b1;
            end
            if (state_d == EXEC && dec_class == CLS_J) begin
               ctrl_d.pc_sel     = PC_SEL_JUMP;
               ctrl_d.pc_write   = 1'b1;
               ctrl_d.instr_done = 1'b1;
            end
            if (state_d == MEM) begin
               ctrl_d.mem_read  = (dec_class == CLS_LW);
               ctrl_d.mem_write = (dec_class == CLS_SW);
            end
            if (state_d == WB) begin
               ctrl_d.reg_write       = 1'b1;
               ctrl_d.instr_done      = 1'b1;
               ctrl_d.reg_dst         = (dec_class == CLS_R) ? REG_DST_RD : REG_DST_RT;
               ctrl_d.data_to_reg_sel = (dec_class == CLS_LW) ? D2R_MEM : D2R_ALU;
            end
         end
         default: ctrl_d = '0;
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if (instr_done) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         active_q  <= 1'b0;
         ctrl_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         ctrl_q    <= ctrl_d;
         retired_q <= retired_d;
      end
   end

   assign bus.PCWrite         = ctrl_q.pc_write;
   assign bus.IRWrite         = ctrl_q.ir_write;
   assign bus.RegDst          = ctrl_q.reg_dst;
   assign bus.ALUSrc          = ctrl_q.alu_src;
   assign bus.ALUCtr          = ctrl_q.alu_ctr;
   assign bus.ExtOp           = ctrl_q.ext_op;
   assign bus.MemRead         = ctrl_q.mem_read;
   assign bus.MemWrite        = ctrl_q.mem_write;
   assign bus.RegWrite        = ctrl_q.reg_write;
   assign bus.Data_to_Reg_sel = ctrl_q.data_to_reg_sel;
   assign bus.PC_sel          = ctrl_q.pc_sel;
   assign bus.instr_done      = instr_done;
   assign bus.illegal         = ctrl_q.illegal;
   assign bus.retired         = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed scenarios plus random instruction mix,
// each cycle compared against a per-instruction expected control sequence.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       pcWrite;
      logic       irWrite;
      logic [1:0] regDst;
      logic       aluSrc;
      logic [4:0] aluCtr;
      logic       extOp;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic [1:0] dtoR;
      logic [1:0] pcSel;
      logic       done;
      logic       illegal;
   } ctlVec_t;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;
   logic [3:0] retExp = 4'd0;
   ctlVec_t expQ[$];
   int      readyQ[$];

   multicycle_ctrl_if #(.CNT_W(4)) bus ();

   multicycle_ctrl #(.CNT_W(4), .MEM_WAIT_EN(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   function automatic ctlVec_t sampleOutputs();
      ctlVec_t v;
      v.pcWrite  = bus.PCWrite;
      v.irWrite  = bus.IRWrite;
      v.regDst   = bus.RegDst;
      v.aluSrc   = bus.ALUSrc;
      v.aluCtr   = bus.ALUCtr;
      v.extOp    = bus.ExtOp;
      v.memRead  = bus.MemRead;
      v.memWrite = bus.MemWrite;
      v.regWrite = bus.RegWrite;
      v.dtoR     = bus.Data_to_Reg_sel;
      v.pcSel    = bus.PC_sel;
      v.done     = bus.instr_done;
      v.illegal  = bus.illegal;
      return v;
   endfunction

   function automatic bit isLegal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000)
         return fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
      return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
   endfunction

   function automatic ctlVec_t aluFields(input logic [5:0] op, input logic [5:0] fn);
      ctlVec_t v = '0;
      case (op)
         6'b000000: begin
            case (fn)
               6'b100011: v.aluCtr = 5'd1;
               6'b100100: v.aluCtr = 5'd3;
               6'b100101: v.aluCtr = 5'd2;
               6'b101010: v.aluCtr = 5'd4;
               default:   v.aluCtr = 5'd0;
            endcase
         end
         6'b001101: begin v.aluSrc = 1'b1; v.aluCtr = 5'd2; end
         6'b001111: begin v.aluSrc = 1'b1; v.aluCtr = 5'd5; end
         6'b100011, 6'b101011: begin v.aluSrc = 1'b1; v.extOp = 1'b1; end
         6'b000100: v.aluCtr = 5'd1;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Expected per-cycle controls for one instruction; readyQ: 0/1 drive in MEM, 2 = free.
   function automatic void buildExpected(input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input int stalls);
      ctlVec_t v;
      ctlVec_t base;
      bit isLw = (op == 6'b100011);
      bit isSw = (op == 6'b101011);
      expQ.delete();
      readyQ.delete();
      v = '0; v.pcWrite = 1'b1; v.irWrite = 1'b1;
      expQ.push_back(v); readyQ.push_back(2);
      v = '0; v.illegal = !isLegal(op, fn);
      expQ.push_back(v); readyQ.push_back(2);
      if (!isLegal(op, fn)) return;
      base = aluFields(op, fn);
      if (op == 6'b000100) begin
         v = base; v.pcSel = 2'd1; v.pcWrite = z; v.done = 1'b1;
         expQ.push_back(v); readyQ.push_back(2);
         return;
      end
      if (op == 6'b000010) begin
         v = '0; v.pcSel = 2'd2; v.pcWrite = 1'b1; v.done = 1'b1;
         expQ.push_back(v); readyQ.push_back(2);
         return;
      end
      expQ.push_back(base); readyQ.push_back(2);
      if (isLw || isSw) begin
         for (int k = 0; k <= stalls; k++) begin
            v = base; v.memRead = isLw; v.memWrite = isSw; v.done = isSw && (k == stalls);
            expQ.push_back(v); readyQ.push_back((k == stalls) ? 1 : 0);
         end
         if (isSw) return;
      end
      v = base; v.regWrite = 1'b1; v.done = 1'b1;
      v.regDst = (op == 6'b000000) ? 2'd1 : 2'd0;
      v.dtoR   = isLw ? 2'd1 : 2'd0;
      expQ.push_back(v); readyQ.push_back(2);
   endfunction

   task automatic checkOutput(input string tag, input ctlVec_t expVec, input logic [3:0] expRet);
      ctlVec_t obs;
      obs = sampleOutputs();
      compared++;
      assert (obs === expVec) else begin
         mismatched++;
         $error("[TB] FAIL %s controls: observed %h expected %h", tag, obs, expVec);
      end
      compared++;
      assert (bus.retired === expRet) else begin
         mismatched++;
         $error("[TB] FAIL %s retired: observed %0d expected %0d", tag, bus.retired, expRet);
      end
   endtask

   // Runs one instruction cycle by cycle; abortAt >= 0 raises reset inside that cycle.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int stalls, input int abortAt);
      buildExpected(op, fn, z, stalls);
      for (int i = 0; i < expQ.size(); i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            bus.opcode = op;
            bus.funct  = fn;
            bus.zero   = z;
         end
         bus.mem_ready = (readyQ[i] == 2) ? 1'($urandom_range(0, 1)) : readyQ[i][0];
         #1;
         checkOutput($sformatf("op=%b fn=%b cyc%0d", op, fn, i), expQ[i], retExp);
         if (i == abortAt) begin
            #2 reset = 1'b1;
            #1;
            retExp = 4'd0;
            checkOutput("abortReset", '0, retExp);
            return;
         end
         if (expQ[i].done) retExp = retExp + 4'd1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [5:0] op;
      logic [5:0] fn;
      logic [5:0] rFuncts[5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] badOps[4]  = '{6'b111111, 6'b000001, 6'b100000, 6'b011000};
      logic [5:0] goodOps[7] = '{6'b000000, 6'b001101, 6'b001111, 6'b100011,
                                 6'b101011, 6'b000100, 6'b000010};

      reset         = 1'b1;
      bus.opcode    = 6'b000000;
      bus.funct     = 6'b100001;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1 checkOutput("reset0", '0, 4'd0);
      @(posedge clk); #1 checkOutput("reset1", '0, 4'd0);
      @(negedge clk) reset = 1'b0;
      #1 checkOutput("postReset", '0, 4'd0);

      applyStimulus(6'b000000, 6'b100001, 1'b0, 0, -1);
      applyStimulus(6'b100011, 6'b000000, 1'b0, 3, -1);
      applyStimulus(6'b000100, 6'b000000, 1'b1, 0, -1);
      applyStimulus(6'b000100, 6'b000000, 1'b0, 0, -1);
      applyStimulus(6'b111111, 6'b000000, 1'b0, 0, -1);

      applyStimulus(6'b101011, 6'b000000, 1'b0, 3, 3);
      @(posedge clk); #1 checkOutput("holdReset", '0, 4'd0);
      @(negedge clk) reset = 1'b0;

      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 7);
         fn   = 6'($urandom);
         if (kind == 7) begin
            op = badOps[$urandom_range(0, 3)];
         end else begin
            op = goodOps[kind];
            if (kind == 0) fn = ($urandom_range(0, 4) == 0) ? 6'b000000 : rFuncts[$urandom_range(0, 4)];
         end
         applyStimulus(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1);
      end

      @(negedge clk) reset = 1'b1;
      #1 checkOutput("wrapReset", '0, 4'd0);
      retExp = 4'd0;
      @(negedge clk) reset = 1'b0;
      for (int n = 0; n < 17; n++) applyStimulus(6'b001101, 6'($urandom), 1'b0, 0, -1);
      @(posedge clk); #1;
      compared++;
      assert (bus.retired === 4'd1) else begin
         mismatched++;
         $error("[TB] FAIL wrap17 retired: observed %0d expected 1", bus.retired);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
